// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the RV32I load/store unit.
//   - funct3 encodings for loads (F3_LB..F3_LHU) and stores (F3_SB..F3_SW)
//   - lsu_state_t : FSM state encoding
//   - is_misaligned() : alignment check for a width/offset pair
//   - is_illegal()    : funct3 legality check for loads and stores
// ---------------------------------------------------------------------------
package lsu_pkg;

    localparam int MEM_AW = 30;  // RAM word address width

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2,
        RESP   = 2'd3
    } lsu_state_t;

    // Halfwords must sit on an even byte, words on a word boundary.
    // funct3[1:0] carries the width for both signed and unsigned loads.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (funct3[1:0])
            2'b01:   mis = off[0];
            2'b10:   mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
        logic ill;
        if (we) begin
            ill = !((funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW));
        end else begin
            ill = !((funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                    (funct3 == F3_LBU) || (funct3 == F3_LHU));
        end
        return ill;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// ---------------------------------------------------------------------------
// lsu_req_if : execute-stage request/response channel of the LSU.
//   master = execute stage (drives req_*), slave = LSU (drives req_ready, resp_*)
// lsu_mem_if : data port of the dual-port RAM.
//   master = LSU (drives addr/wdata/byte_en/wr), slave = RAM (drives mem_rdata)
// ---------------------------------------------------------------------------
interface lsu_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface lsu_mem_if;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_en;
    logic        mem_wr;
    logic [31:0] mem_rdata;

    modport master (
        output mem_addr, mem_wdata, mem_byte_en, mem_wr,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_byte_en, mem_wr,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purely combinational lane logic shared by the store and load paths.
//   funct3_i  : RV32I width/sign code
//   off_i     : byte offset within the word (addr[1:0])
//   st_data_i : right-aligned store data
//   ld_word_i : raw 32-bit word read from the RAM
//   byte_en_o : lane enables for the access
//   st_data_o : store data replicated across all lanes
//   ld_data_o : selected lane(s), sign- or zero-extended to 32 bits
// ---------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] ld_word_i,
    output logic [3:0]  byte_en_o,
    output logic [31:0] st_data_o,
    output logic [31:0] ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statements can infer a latch.
    always_comb begin
        byte_en_o = 4'b1111;
        st_data_o = st_data_i;
        case (funct3_i[1:0])
            2'b00: begin
                byte_en_o = 4'b0001 << off_i;
                st_data_o = {4{st_data_i[7:0]}};
            end
            2'b01: begin
                byte_en_o = off_i[1] ? 4'b1100 : 4'b0011;
                st_data_o = {2{st_data_i[15:0]}};
            end
            default: begin
                byte_en_o = 4'b1111;
                st_data_o = st_data_i;
            end
        endcase
    end

    always_comb begin
        ld_byte = ld_word_i[7:0];
        case (off_i)
            2'd0: ld_byte = ld_word_i[7:0];
            2'd1: ld_byte = ld_word_i[15:8];
            2'd2: ld_byte = ld_word_i[23:16];
            2'd3: ld_byte = ld_word_i[31:24];
            default: ld_byte = ld_word_i[7:0];
        endcase
        ld_half = off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];

        ld_data_o = ld_word_i;
        case (funct3_i)
            F3_LB:   ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            F3_LH:   ld_data_o = {{16{ld_half[15]}}, ld_half};
            F3_LBU:  ld_data_o = {24'd0, ld_byte};
            F3_LHU:  ld_data_o = {16'd0, ld_half};
            default: ld_data_o = ld_word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Data-side master of the dual-port RAM. Accepts one RV32I load/store per
// request, drives the RAM word address, lane enables and replicated write
// data, and returns the extended load result one cycle after the RAM's
// registered read. Misaligned or illegal ops are answered with resp_err and
// never touch memory.
//   clk : clock
//   rst : synchronous reset, active-high
//   req : lsu_req_if.slave  - request in, response out
//   mem : lsu_mem_if.master - RAM data port
// Latency accept->resp_valid: error 1, store 2, load 3 cycles.
// ---------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    lsu_req_if.slave   req,
    lsu_mem_if.master  mem
);

    lsu_state_t  state_q, state_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        wr_q, wr_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  f3_q, f3_d;
    logic        we_q, we_d;

    logic        idle;
    logic        accept;
    logic        req_bad;
    logic [2:0]  sel_f3;
    logic [1:0]  sel_off;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;

    assign idle    = (state_q == IDLE);
    assign accept  = req.req_valid && idle;
    assign req_bad = is_illegal(req.req_we, req.req_funct3) ||
                     is_misaligned(req.req_funct3, req.req_addr[1:0]);

    // The aligner sees the live request while idle (store lanes are built at
    // accept) and the latched op afterwards (load extraction in RDWAIT).
    assign sel_f3  = idle ? req.req_funct3    : f3_q;
    assign sel_off = idle ? req.req_addr[1:0] : off_q;

    lsu_align u_align (
        .funct3_i  (sel_f3),
        .off_i     (sel_off),
        .st_data_i (req.req_wdata),
        .ld_word_i (mem.mem_rdata),
        .byte_en_o (al_be),
        .st_data_o (al_wdata),
        .ld_data_o (al_rdata)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        wr_d         = wr_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        rdata_d      = rdata_q;
        off_d        = off_q;
        f3_d         = f3_q;
        we_d         = we_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    off_d = req.req_addr[1:0];
                    f3_d  = req.req_funct3;
                    we_d  = req.req_we;
                    if (req_bad) begin
                        // Memory-side registers are left untouched.
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        rdata_d      = 32'd0;
                        state_d      = RESP;
                    end else begin
                        addr_d  = req.req_addr[31:2];
                        be_d    = al_be;
                        wdata_d = al_wdata;
                        wr_d    = req.req_we;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                wr_d = 1'b0;
                if (we_q) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    rdata_d      = 32'd0;
                    state_d      = RESP;
                end else begin
                    state_d = RDWAIT;
                end
            end
            RDWAIT: begin
                // mem_rdata now holds the word addressed during ACCESS.
                rdata_d      = al_rdata;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                state_d      = RESP;
            end
            RESP: begin
                // Dropping the lane enables freezes the RAM read register.
                resp_valid_d = 1'b0;
                resp_err_d   = 1'b0;
                be_d         = 4'b0000;
                wr_d         = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            wr_q         <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= '0;
            off_q        <= '0;
            f3_q         <= '0;
            we_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            wr_q         <= wr_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            rdata_q      <= rdata_d;
            off_q        <= off_d;
            f3_q         <= f3_d;
            we_q         <= we_d;
        end
    end

    assign req.req_ready  = idle;
    assign req.resp_valid = resp_valid_q;
    assign req.resp_err   = resp_err_q;
    assign req.resp_rdata = rdata_q;

    assign mem.mem_addr    = addr_q;
    assign mem.mem_wdata   = wdata_q;
    assign mem.mem_byte_en = be_q;
    assign mem.mem_wr      = wr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Table of load/store vectors with expected ACCESS-cycle bus values; each
// response is predicted into a scoreboard queue at accept time and checked
// (data, error flag, latency) when resp_valid appears. Hand-written
// sequences cover response-to-ready timing and reset mid-operation.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    logic clk;
    logic rst;
    int   cyc;
    int   n_tests;
    int   n_fail;

    lsu_req_if req_bus ();
    lsu_mem_if mem_bus ();

    load_store_unit dut (
        .clk (clk),
        .rst (rst),
        .req (req_bus),
        .mem (mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM data port model: byte-lane write, registered read that holds its
    // value while no lane is enabled.
    logic [31:0] ram [0:63];
    always @(posedge clk) begin
        if (mem_bus.mem_wr) begin
            for (int b = 0; b < 4; b++)
                if (mem_bus.mem_byte_en[b])
                    ram[mem_bus.mem_addr[5:0]][b*8 +: 8] <= mem_bus.mem_wdata[b*8 +: 8];
        end
        if (|mem_bus.mem_byte_en)
            mem_bus.mem_rdata <= ram[mem_bus.mem_addr[5:0]];
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        int          idx;
        logic        err;
        logic [31:0] rdata;
        int          due;
    } sb_t;

    sb_t  sb [$];
    vec_t vecs [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic err, input logic [3:0] be,
                                input logic [31:0] mwdata, input logic [31:0] rdata);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.err = err; v.be = be; v.mwdata = mwdata; v.rdata = rdata;
        return v;
    endfunction

    // Response monitor: pops the scoreboard on every resp_valid.
    always @(negedge clk) begin
        if (req_bus.resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                check($sformatf("op%0d resp_err", e.idx), {31'd0, req_bus.resp_err}, {31'd0, e.err});
                check($sformatf("op%0d resp_rdata", e.idx), req_bus.resp_rdata, e.rdata);
                check($sformatf("op%0d latency_cycle", e.idx), cyc, e.due);
            end
        end
        if (mem_bus.mem_wr === 1'b1)
            check("wr_with_lanes", {31'd0, (mem_bus.mem_byte_en != 4'b0000)}, 32'd1);
    end

    // Presents one op, waits (bounded) for acceptance, predicts its response
    // and checks the bus in the cycle after the accept edge.
    task automatic issue(input vec_t v, input int idx, input bit expect_resp);
        int acc;
        int lat;
        sb_t e;
        @(negedge clk);
        req_bus.req_valid  = 1'b1;
        req_bus.req_we     = v.we;
        req_bus.req_funct3 = v.f3;
        req_bus.req_addr   = v.addr;
        req_bus.req_wdata  = v.wdata;
        for (int i = 0; i < 20 && req_bus.req_ready !== 1'b1; i++) @(negedge clk);
        if (req_bus.req_ready !== 1'b1) begin
            check($sformatf("op%0d accept_timeout", idx), 32'd0, 32'd1);
            req_bus.req_valid = 1'b0;
            return;
        end
        acc = cyc;
        lat = v.err ? 1 : (v.we ? 2 : 3);
        @(posedge clk);
        #1;
        req_bus.req_valid = 1'b0;
        if (expect_resp) begin
            e.idx = idx; e.err = v.err; e.rdata = v.err ? 32'd0 : (v.we ? 32'd0 : v.rdata);
            e.due = acc + lat;
            sb.push_back(e);
        end
        @(negedge clk);
        check($sformatf("op%0d busy_ready", idx), {31'd0, req_bus.req_ready}, 32'd0);
        if (v.err) begin
            check($sformatf("op%0d err_no_wr", idx), {31'd0, mem_bus.mem_wr}, 32'd0);
            check($sformatf("op%0d err_no_lanes", idx), {28'd0, mem_bus.mem_byte_en}, 32'd0);
        end else begin
            check($sformatf("op%0d mem_addr", idx), {2'd0, mem_bus.mem_addr}, {2'd0, v.addr[31:2]});
            check($sformatf("op%0d byte_en", idx), {28'd0, mem_bus.mem_byte_en}, {28'd0, v.be});
            check($sformatf("op%0d mem_wr", idx), {31'd0, mem_bus.mem_wr}, {31'd0, v.we});
            if (v.we)
                check($sformatf("op%0d mem_wdata", idx), mem_bus.mem_wdata, v.mwdata);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            check("resp_timeout", sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " resp_valid"}, {31'd0, req_bus.resp_valid}, 32'd0);
        check({tag, " resp_err"}, {31'd0, req_bus.resp_err}, 32'd0);
        check({tag, " mem_wr"}, {31'd0, mem_bus.mem_wr}, 32'd0);
        check({tag, " byte_en"}, {28'd0, mem_bus.mem_byte_en}, 32'd0);
        check({tag, " mem_addr"}, {2'd0, mem_bus.mem_addr}, 32'd0);
        check({tag, " mem_wdata"}, mem_bus.mem_wdata, 32'd0);
        check({tag, " resp_rdata"}, req_bus.resp_rdata, 32'd0);
    endtask

    initial begin
        vec_t v;
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        rst     = 1'b1;
        req_bus.req_valid  = 1'b0;
        req_bus.req_we     = 1'b0;
        req_bus.req_funct3 = 3'b000;
        req_bus.req_addr   = 32'd0;
        req_bus.req_wdata  = 32'd0;
        for (int i = 0; i < 64; i++) ram[i] = 32'd0;
        ram[5] = 32'h5555_6666;

        //             we    f3      addr        wdata          err   be       mem_wdata      rdata
        vecs[0]  = mk(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0);
        vecs[1]  = mk(1'b0, 3'b010, 32'h10, 32'h0,         1'b0, 4'b1111, 32'h0, 32'hDEAD_BEEF);
        vecs[2]  = mk(1'b1, 3'b010, 32'h10, 32'h80FF_7F01, 1'b0, 4'b1111, 32'h80FF_7F01, 32'h0);
        vecs[3]  = mk(1'b0, 3'b000, 32'h12, 32'h0,         1'b0, 4'b0100, 32'h0, 32'hFFFF_FFFF);
        vecs[4]  = mk(1'b0, 3'b100, 32'h12, 32'h0,         1'b0, 4'b0100, 32'h0, 32'h0000_00FF);
        vecs[5]  = mk(1'b0, 3'b000, 32'h11, 32'h0,         1'b0, 4'b0010, 32'h0, 32'h0000_007F);
        vecs[6]  = mk(1'b0, 3'b000, 32'h13, 32'h0,         1'b0, 4'b1000, 32'h0, 32'hFFFF_FF80);
        vecs[7]  = mk(1'b0, 3'b001, 32'h12, 32'h0,         1'b0, 4'b1100, 32'h0, 32'hFFFF_80FF);
        vecs[8]  = mk(1'b0, 3'b101, 32'h12, 32'h0,         1'b0, 4'b1100, 32'h0, 32'h0000_80FF);
        vecs[9]  = mk(1'b0, 3'b001, 32'h10, 32'h0,         1'b0, 4'b0011, 32'h0, 32'h0000_7F01);
        vecs[10] = mk(1'b1, 3'b001, 32'h16, 32'h1234_ABCD, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0);
        vecs[11] = mk(1'b0, 3'b010, 32'h14, 32'h0,         1'b0, 4'b1111, 32'h0, 32'hABCD_6666);
        vecs[12] = mk(1'b1, 3'b000, 32'h1B, 32'h0000_00A5, 1'b0, 4'b1000, 32'hA5A5_A5A5, 32'h0);
        vecs[13] = mk(1'b0, 3'b010, 32'h18, 32'h0,         1'b0, 4'b1111, 32'h0, 32'hA500_0000);
        vecs[14] = mk(1'b0, 3'b010, 32'h02, 32'h0,         1'b1, 4'b0000, 32'h0, 32'h0);
        vecs[15] = mk(1'b1, 3'b001, 32'h03, 32'h1111_2222, 1'b1, 4'b0000, 32'h0, 32'h0);
        vecs[16] = mk(1'b0, 3'b011, 32'h10, 32'h0,         1'b1, 4'b0000, 32'h0, 32'h0);
        vecs[17] = mk(1'b1, 3'b100, 32'h10, 32'h0,         1'b1, 4'b0000, 32'h0, 32'h0);
        vecs[18] = mk(1'b0, 3'b101, 32'h11, 32'h0,         1'b1, 4'b0000, 32'h0, 32'h0);
        vecs[19] = mk(1'b0, 3'b110, 32'h10, 32'h0,         1'b1, 4'b0000, 32'h0, 32'h0);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset req_ready", {31'd0, req_bus.req_ready}, 32'd1);
        check_all_zero("reset");

        for (int i = 0; i < 20; i++) issue(vecs[i], i, 1'b1);
        wait_drain();
        check("ram word4", ram[4], 32'h80FF_7F01);
        check("ram word5", ram[5], 32'hABCD_6666);

        // Error response: ready stays low in RESP, returns the next cycle,
        // and the memory port stays quiet throughout.
        v = mk(1'b0, 3'b010, 32'h02, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0);
        issue(v, 100, 1'b1);
        #1;
        check("err resp_valid", {31'd0, req_bus.resp_valid}, 32'd1);
        check("err ready_in_resp", {31'd0, req_bus.req_ready}, 32'd0);
        @(negedge clk);
        #1;
        check("err ready_after", {31'd0, req_bus.req_ready}, 32'd1);
        check("err lanes_after", {28'd0, mem_bus.mem_byte_en}, 32'd0);
        wait_drain();

        // Reset during RDWAIT of a load: dropped, everything cleared.
        v = mk(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 4'b1111, 32'h0, 32'h80FF_7F01);
        issue(v, 101, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_all_zero("rst_rdwait");
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("rst_rdwait ready", {31'd0, req_bus.req_ready}, 32'd1);
        repeat (4) @(negedge clk);

        // Reset during ACCESS of a store: the write still lands.
        v = mk(1'b1, 3'b010, 32'h1C, 32'hCAFE_F00D, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0);
        issue(v, 102, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rst_access ram word7", ram[7], 32'hCAFE_F00D);
        check_all_zero("rst_access");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("rst_access ready", {31'd0, req_bus.req_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
